// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device. The host first inhibits the clock
// (request-to-send), then drives the start bit. It shifts out eight data bits
// LSB first plus odd parity on the device's falling clock edges, releases the
// data line for the stop bit, and samples the device's acknowledge. A watchdog
// aborts the transfer if the device stops clocking.
//
// Ports:
//   sysclk       in   system clock, rising-edge active
//   reset        in   asynchronous active-high reset
//   wr_ps2       in   one-cycle send request, honoured only while tx_idle=1
//   din[7:0]     in   command byte to transmit
//   ps2c_in      in   raw PS/2 clock line (asynchronous)
//   ps2d_in      in   raw PS/2 data line (asynchronous)
//   ps2c_oe      out  registered open-drain enable for clock (1 = pull low)
//   ps2d_oe      out  registered open-drain enable for data (1 = pull low)
//   tx_idle      out  1 while idle; gates the receiver
//   tx_done_tick out  one-cycle pulse at the end of every accepted transfer
//   tx_err       out  1 = no ack or timeout; valid from tx_done_tick onward
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StRts, StStart, StData, StStop} state_e;

    // Line conditioning
    logic [7:0] filt_sr_q;
    logic       filt_q, filt_prev_q;
    logic [1:0] d_sync_q;
    logic       ps2d_sync;
    logic       fall_edge;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            filt_sr_q   <= '1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            d_sync_q    <= '1;
        end else begin
            filt_sr_q   <= {ps2c_in, filt_sr_q[7:1]};
            // Change only on a unanimous window; otherwise hold the last value.
            if (filt_sr_q == 8'h00) begin
                filt_q <= 1'b0;
            end else if (filt_sr_q == 8'hFF) begin
                filt_q <= 1'b1;
            end
            filt_prev_q <= filt_q;
            d_sync_q    <= {d_sync_q[0], ps2d_in};
        end
    end

    assign ps2d_sync = d_sync_q[1];
    assign fall_edge = filt_prev_q & ~filt_q;

    // Transmit FSM
    state_e            state_q, state_d;
    logic [8:0]        sr_q, sr_d;        // {parity, data}; bit 0 is on the wire
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [InhW-1:0]   inh_cnt_q, inh_cnt_d;
    logic [WdW-1:0]    wd_q, wd_d;
    logic              c_oe_q, c_oe_d;
    logic              d_oe_q, d_oe_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wd_hit;

    assign wd_hit = (wd_q == WdW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        wd_d      = wd_q;
        c_oe_d    = c_oe_q;
        d_oe_d    = d_oe_q;
        done_d    = 1'b0;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                if (wr_ps2) begin
                    sr_d      = {~^din, din};
                    err_d     = 1'b0;
                    inh_cnt_d = '0;
                    c_oe_d    = 1'b1;
                    state_d   = StRts;
                end
            end
            StRts: begin
                if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
                    c_oe_d    = 1'b0;
                    d_oe_d    = 1'b1;     // start bit
                    wd_d      = '0;
                    bit_cnt_d = '0;
                    state_d   = StStart;
                end else begin
                    inh_cnt_d = inh_cnt_q + InhW'(1);
                end
            end
            StStart, StData, StStop: begin
                if (fall_edge) begin
                    wd_d = '0;
                    if (state_q == StStart) begin
                        d_oe_d  = ~sr_q[0];
                        state_d = StData;
                    end else if (state_q == StData) begin
                        if (bit_cnt_q == 4'd8) begin
                            d_oe_d  = 1'b0;   // stop bit via pull-up
                            state_d = StStop;
                        end else begin
                            sr_d      = {1'b1, sr_q[8:1]};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            d_oe_d    = ~sr_q[1];
                        end
                    end else begin
                        err_d   = ps2d_sync;  // device pulls data low to ack
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else if (wd_hit) begin
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            default: begin
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            sr_q      <= '1;
            bit_cnt_q <= '1;
            inh_cnt_q <= '1;
            wd_q      <= '1;
            c_oe_q    <= 1'b0;
            d_oe_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            wd_q      <= wd_d;
            c_oe_q    <= c_oe_d;
            d_oe_q    <= d_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2c_oe      = c_oe_q;
    assign ps2d_oe      = d_oe_q;
    assign tx_idle      = (state_q == StIdle);
    assign tx_done_tick = done_q;
    assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device,
// expectation queue filled at issue time, monitor checking at tx_done_tick.
module tb_ps2_host_tx;

    localparam int unsigned Inhibit = 20;
    localparam int unsigned Timeout = 500;
    localparam int Half = 40;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;
    logic       ps2c_line, ps2d_line;

    assign ps2c_line = ~(ps2c_oe | dev_clk_low | glitch);
    assign ps2d_line = ~(ps2d_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inhibit),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c_in     (ps2c_line),
        .ps2d_in     (ps2d_line),
        .ps2c_oe     (ps2c_oe),
        .ps2d_oe     (ps2d_oe),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [10:0] frame;
        bit          check_frame;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] dev_frame = '0;

    // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int          ones = 0;
        logic [10:0] f;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic issue(input logic [7:0] b, input bit chk, input bit err);
        exp_t e;
        e.frame = model_frame(b);
        e.check_frame = chk;
        e.err = err;
        exp_q.push_back(e);
        @(negedge sysclk);
        din = b;
        wr_ps2 = 1'b1;
        @(negedge sysclk);
        wr_ps2 = 1'b0;
    endtask

    // Device: detect request-to-send, then clock n_falls bits, sampling data
    // at the end of each high half; bit 10 is followed by the ack.
    task automatic device(input int n_falls, input bit ack, input int glitch_bit);
        int n = 0;
        int len = 0;
        dev_frame = '0;
        while (!ps2c_oe && n < 200) begin
            n++;
            @(negedge sysclk);
        end
        check("rts_seen", 32'(ps2c_oe), 1);
        while (ps2c_oe && len < 1000) begin
            len++;
            @(negedge sysclk);
        end
        check("rts_len", len, Inhibit);
        for (int i = 0; i < n_falls; i++) begin
            for (int c = 0; c < Half; c++) begin
                if (i == glitch_bit && c == 15) glitch = 1'b1;
                if (i == glitch_bit && c == 17) glitch = 1'b0;
                @(negedge sysclk);
            end
            dev_frame[i] = ps2d_line;
            if (i == 10) dev_data_low = ack;
            dev_clk_low = 1'b1;
            repeat (Half) @(negedge sysclk);
            dev_clk_low = 1'b0;
            dev_data_low = 1'b0;
        end
    endtask

    task automatic settle(input bit err);
        repeat (20) @(negedge sysclk);
        check("single_done", 32'(exp_q.size()), 0);
        check("err_hold", 32'(tx_err), 32'(err));
        check("idle_after", 32'(tx_idle), 1);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge sysclk);
            if (tx_done_tick === 1'b1) begin
                check("done_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tx_err", 32'(tx_err), 32'(e.err));
                    check("idle_at_done", 32'(tx_idle), 1);
                    check("oe_at_done", {30'd0, ps2c_oe, ps2d_oe}, 0);
                    if (e.check_frame) check("frame", 32'(dev_frame), 32'(e.frame));
                end
            end
        end
    end

    initial begin
        #700000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [7:0]  b;
        bit          ack;

        #3;
        check("rst_c_oe", 32'(ps2c_oe), 0);
        check("rst_d_oe", 32'(ps2d_oe), 0);
        check("rst_idle", 32'(tx_idle), 1);
        check("rst_done", 32'(tx_done_tick), 0);
        check("rst_err", 32'(tx_err), 0);
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        repeat (5) @(negedge sysclk);

        // 0xED with ack
        issue(8'hED, 1'b1, 1'b0);
        device(11, 1'b1, -1);
        check("ed_frame_literal", 32'(dev_frame), 32'(11'b11111011010));
        settle(1'b0);

        // 0x01, no ack: parity 0
        issue(8'h01, 1'b1, 1'b1);
        device(11, 1'b0, -1);
        check("parity_01", 32'(dev_frame[9]), 0);
        settle(1'b1);

        // Device stops after the 4th falling edge
        issue(8'hA5, 1'b0, 1'b1);
        device(4, 1'b1, -1);
        n = 0;
        while (tx_done_tick !== 1'b1 && n < 700) begin
            n++;
            @(negedge sysclk);
        end
        check("timeout_window", 32'((n + Half) >= 500 && (n + Half) <= 530), 1);
        // Request in the cycle right after the done pulse
        begin
            exp_t e;
            e.frame = model_frame(8'hED);
            e.check_frame = 1'b1;
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        din = 8'hED;
        wr_ps2 = 1'b1;
        @(negedge sysclk);
        wr_ps2 = 1'b0;
        device(11, 1'b1, -1);
        settle(1'b0);

        // Request while busy must be ignored
        issue(8'hF4, 1'b1, 1'b0);
        fork
            device(11, 1'b1, -1);
            begin
                repeat (Inhibit + 300) @(negedge sysclk);
                din = 8'h55;
                wr_ps2 = 1'b1;
                @(negedge sysclk);
                wr_ps2 = 1'b0;
            end
        join
        settle(1'b0);
        repeat (100) @(negedge sysclk);
        check("no_second_xfer", 32'(ps2c_oe), 0);

        // Reset mid-DATA while data is pulled low
        issue(8'hED, 1'b0, 1'b0);
        device(2, 1'b1, -1);
        n = 0;
        while (ps2d_oe !== 1'b1 && n < 20) begin
            n++;
            @(negedge sysclk);
        end
        check("d_oe_before_reset", 32'(ps2d_oe), 1);
        @(posedge sysclk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("rst_async_oe", {30'd0, ps2c_oe, ps2d_oe}, 0);
        check("rst_async_idle", 32'(tx_idle), 1);
        check("rst_async_done", 32'(tx_done_tick), 0);
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        repeat (5) @(negedge sysclk);
        issue(8'hED, 1'b1, 1'b0);
        device(11, 1'b1, -1);
        settle(1'b0);

        // Short clock glitch during DATA
        issue(8'h3C, 1'b1, 1'b0);
        device(11, 1'b1, 5);
        settle(1'b0);

        // Random bytes and ack behaviour
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            issue(b, 1'b1, !ack);
            device(11, ack, -1);
            settle(!ack);
        end

        repeat (50) @(negedge sysclk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000: sysclk cycles the host holds PS/2 clock low in request-to-send (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 200000: maximum sysclk cycles between device clock falling edges before abort (2 ms at 100 MHz).
REQ-003 sysclk  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 wr_ps2  in  1  one-cycle request to send din; honoured only when tx_idle=1.
REQ-006 din  in  8  command byte to transmit (e.g. 0xED set-LEDs).
REQ-007 ps2c_in, ps2d_in  in  1 each  raw sensed PS/2 clock and data lines (asynchronous).
REQ-008 ps2c_oe, ps2d_oe  out  1 each  registered open-drain enables; 1 = pull line low, 0 = release.
REQ-009 tx_idle  out  1  1 in IDLE; used to gate the existing receiver's rx_en.
REQ-010 tx_done_tick  out  1  one-cycle pulse at end of every accepted transfer, including aborted ones.
REQ-011 tx_err  out  1  result flag, valid from tx_done_tick, held until next accepted wr_ps2.

Function
REQ-012 ps2d_in SHALL pass a 2-flop synchronizer; ps2d_sync is its output.
REQ-013 ps2c_in SHALL pass an 8-sample shift-register filter: filtered clock goes 0 when all 8 samples are 0, 1 when all are 1, else holds.
REQ-014 fall_edge SHALL be a one-cycle pulse when filtered clock was 1 on the previous cycle and is 0 now.
REQ-015 States: IDLE, RTS, START, DATA, STOP; encoding free.
REQ-016 IDLE: oe outputs 0, tx_idle=1; wr_ps2=1 latches {odd parity = ~^din, din} into a 9-bit shift register, clears tx_err, enters RTS next cycle.
REQ-017 RTS: ps2c_oe=1, ps2d_oe=0 for exactly INHIBIT_CYCLES cycles (wr_ps2 at edge t -> ps2c_oe=1 for cycles t+1..t+INHIBIT_CYCLES), then START; fall_edge ignored.
REQ-018 START: ps2c_oe=0, ps2d_oe=1 (start bit 0); first fall_edge -> DATA presenting bit0.
REQ-019 DATA: ps2d_oe = ~current bit (LSB first, parity last); each fall_edge advances one bit; fall_edge while parity is presented -> STOP.
REQ-020 STOP: both oe 0 (stop bit 1 by pull-up); next fall_edge samples ps2d_sync: 0 = device ack (tx_err=0), 1 = no ack (tx_err=1); pulse tx_done_tick, go IDLE.
REQ-021 Total device falling edges per transfer: 11 (1 start, 9 data/parity, 1 ack).
REQ-022 Watchdog counter SHALL clear on entering START and on every fall_edge in START/DATA/STOP; reaching TIMEOUT_CYCLES -> release both lines, tx_err=1, tx_done_tick pulse, IDLE.
REQ-023 wr_ps2 while tx_idle=0 SHALL be ignored, with no effect on the byte in flight.
REQ-024 tx_done_tick and the IDLE transition occur on the same edge; wr_ps2 asserted in the following cycle is accepted.

Reset
REQ-025 reset=1 SHALL force immediately, without waiting for sysclk: IDLE, ps2c_oe=0, ps2d_oe=0, tx_idle=1, tx_done_tick=0, tx_err=0, counters, filter and synchronizer cleared to all ones (lines released).
REQ-026 Reset asserted mid-transfer SHALL release both lines at once; no tx_done_tick pulse is produced for the abandoned byte.

Verification (bench uses INHIBIT_CYCLES=20, TIMEOUT_CYCLES=500, device model clocking at 40 sysclk per half period)
REQ-027 wr_ps2 with din=0xED, device acks -> ps2c_oe high exactly 20 cycles; device-sampled bits 0,1,0,1,1,0,1,1,1,1,1 (start, data LSB first, parity 1, stop); tx_done_tick once, tx_err=0.
REQ-028 din=0x01, device leaves data high at ack -> parity bit 0 sampled; tx_done_tick with tx_err=1.
REQ-029 Device stops clocking after 4th falling edge -> 500 cycles later both oe 0, tx_done_tick, tx_err=1, tx_idle=1.
REQ-030 wr_ps2 pulsed with din=0x55 during DATA of 0xF4 transfer -> device receives 0xF4 only, single tx_done_tick.
REQ-031 Reset asserted in DATA with ps2d_oe=1 -> ps2d_oe and ps2c_oe 0 before next sysclk edge; no tx_done_tick; subsequent 0xED transfer correct.
REQ-032 2-cycle low glitch on ps2c_in during DATA -> no bit advance.
